// File: rtl/reg_status_file_if.sv
// Bus bundle for the architectural register/rename-status file: issue,
// two source-operand lookups, commit, flush and the busy population count.
// master = dispatch/ROB side, slave = the register file itself.
interface reg_status_file_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int REG_W = 5
);
    // Issue: rename a destination register to an in-flight ROB tag
    logic             issue_valid;
    logic [REG_W-1:0] issue_rd;
    logic [TAG_W-1:0] issue_tag;

    // Source-operand lookups for dispatch
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_val;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_val;

    // Commit: architectural write plus conditional rename release
    logic             commit_valid;
    logic [REG_W-1:0] commit_rd;
    logic [TAG_W-1:0] commit_tag;
    logic [XLEN-1:0]  commit_data;

    // Mispredict recovery and occupancy
    logic             flush;
    logic [REG_W:0]   busy_cnt;

    modport master (
        output issue_valid, issue_rd, issue_tag,
        output rs1, rs2,
        input  rs1_busy, rs1_tag, rs1_val,
        input  rs2_busy, rs2_tag, rs2_val,
        output commit_valid, commit_rd, commit_tag, commit_data,
        output flush,
        input  busy_cnt
    );

    modport slave (
        input  issue_valid, issue_rd, issue_tag,
        input  rs1, rs2,
        output rs1_busy, rs1_tag, rs1_val,
        output rs2_busy, rs2_tag, rs2_val,
        input  commit_valid, commit_rd, commit_tag, commit_data,
        input  flush,
        output busy_cnt
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB
// tag) for the out-of-order core. Issue renames a destination, commit writes
// the value and releases the rename only when the tag still matches, flush
// drops every in-flight rename. Two combinational source lookups per cycle.
// Register 0 is hardwired to zero and never becomes busy.
//
// Optional feature: define REG_COMMIT_BYPASS_EN to let a lookup see a
// same-cycle matching commit (busy=0, val=commit_data). Without it the
// lookup shows pre-commit state and the release appears one cycle later.
module reg_status_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int REG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    reg_status_file_if.slave  bus
);

    localparam int CNT_W = REG_W + 1;

    // Architectural state
    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    // Qualified requests; index 0 is the zero register and absorbs nothing
    logic issue_en;
    logic commit_en;
    logic commit_match;

    // Decode the requests that actually touch state this cycle
    always_comb begin
        issue_en     = bus.issue_valid && (bus.issue_rd != '0) && !bus.flush;
        commit_en    = bus.commit_valid && (bus.commit_rd != '0);
        commit_match = commit_en && busy_q[bus.commit_rd]
                       && (tag_q[bus.commit_rd] == bus.commit_tag);
    end

    // Next-state for values, busy bits and tags; later statements take priority
    always_comb begin
        // NOTE: every target gets its hold value first so no path through this block can infer a latch.
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;

        // Commit always writes the value, even under flush; it releases the
        // rename only if this commit is still the youngest producer.
        if (commit_en) begin
            regs_d[bus.commit_rd] = bus.commit_data;
            if (commit_match) begin
                busy_d[bus.commit_rd] = 1'b0;
            end
        end

        // A same-cycle issue to the committing register overrides the release.
        if (issue_en) begin
            busy_d[bus.issue_rd] = 1'b1;
            tag_d[bus.issue_rd]  = bus.issue_tag;
        end

        // Mispredict discards every in-flight rename; values and tags stay.
        if (bus.flush) begin
            busy_d = '0;
        end

        // Keep the zero register pinned regardless of what arrived above.
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // Occupancy tracks the next-state busy vector so it is exact once registered
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers: synchronous reset wins over the global enable
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the value array is cleared on reset as well, since lookups are combinational and must read 0 straight out of reset.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else if (rdy) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Source lookups
    logic [REG_W-1:0] rs_idx  [2];
    logic             rd_busy [2];
    logic [TAG_W-1:0] rd_tag  [2];
    logic [XLEN-1:0]  rd_val  [2];

    // Combinational read of current state for both ports, with optional commit bypass
    always_comb begin
        rs_idx[0] = bus.rs1;
        rs_idx[1] = bus.rs2;
        for (int p = 0; p < 2; p++) begin
            rd_busy[p] = busy_q[rs_idx[p]];
            rd_tag[p]  = tag_q[rs_idx[p]];
            rd_val[p]  = regs_q[rs_idx[p]];
`ifdef REG_COMMIT_BYPASS_EN
            // A matching commit this cycle resolves the operand immediately,
            // sparing dispatch a wait on the CDB for a tag that is retiring now.
            if (bus.commit_valid && (bus.commit_rd == rs_idx[p])
                && (rs_idx[p] != '0) && busy_q[rs_idx[p]]
                && (tag_q[rs_idx[p]] == bus.commit_tag)) begin
                rd_busy[p] = 1'b0;
                rd_val[p]  = bus.commit_data;
            end
`else
            // Pre-commit state is shown; the release is visible next cycle.
`endif
            if (rs_idx[p] == '0) begin
                rd_busy[p] = 1'b0;
                rd_tag[p]  = '0;
                rd_val[p]  = '0;
            end
        end
    end

    // Drive the slave-side outputs
    always_comb begin
        bus.rs1_busy = rd_busy[0];
        bus.rs1_tag  = rd_tag[0];
        bus.rs1_val  = rd_val[0];
        bus.rs2_busy = rd_busy[1];
        bus.rs2_tag  = rd_tag[1];
        bus.rs2_val  = rd_val[1];
        bus.busy_cnt = busy_cnt_q;
    end

    // Structural invariants: zero register never busy, occupancy below NREG
    zero_never_busy: assert property (@(posedge clk) disable iff (rst) !busy_q[0]);
    cnt_in_range:    assert property (@(posedge clk) disable iff (rst)
                                      busy_cnt_q <= CNT_W'(NREG - 1));

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file. Each stimulus cycle pushes its
// hand-computed expected lookup/occupancy response into a queue; a monitor
// on the falling edge pops the entry for the current cycle and compares.
module tb_reg_status_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int REG_W = 5;

`ifdef REG_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    logic rdy;

    reg_status_file_if #(.XLEN(XLEN), .TAG_W(TAG_W), .REG_W(REG_W)) bus ();

    reg_status_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string       name;
        int          cyc;
        bit          b1;
        logic [3:0]  t1;
        logic [31:0] v1;
        bit          b2;
        logic [3:0]  t2;
        logic [31:0] v2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare the DUT against the expectation queued for this cycle
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc_cnt) begin
            e = exp_q.pop_front();
            check({e.name, ".missed_cycle"}, 32'(cyc_cnt), 32'(e.cyc));
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            check({e.name, ".rs1_busy"}, 32'(bus.rs1_busy), 32'(e.b1));
            check({e.name, ".rs1_tag"},  32'(bus.rs1_tag),  32'(e.t1));
            check({e.name, ".rs1_val"},  bus.rs1_val,       e.v1);
            check({e.name, ".rs2_busy"}, 32'(bus.rs2_busy), 32'(e.b2));
            check({e.name, ".rs2_tag"},  32'(bus.rs2_tag),  32'(e.t2));
            check({e.name, ".rs2_val"},  bus.rs2_val,       e.v2);
            check({e.name, ".busy_cnt"}, 32'(bus.busy_cnt), 32'(e.cnt));
        end
    end

    // One cycle of stimulus plus the response expected before the next edge
    task automatic step(
        input string name, input bit r,
        input bit iv, input logic [4:0] ird, input logic [3:0] itag,
        input bit cv, input logic [4:0] crd, input logic [3:0] ctag, input logic [31:0] cdata,
        input bit fl, input logic [4:0] s1, input logic [4:0] s2,
        input bit b1, input logic [3:0] t1, input logic [31:0] v1,
        input bit b2, input logic [3:0] t2, input logic [31:0] v2,
        input logic [5:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rdy              = r;
        bus.issue_valid  = iv;
        bus.issue_rd     = ird;
        bus.issue_tag    = itag;
        bus.commit_valid = cv;
        bus.commit_rd    = crd;
        bus.commit_tag   = ctag;
        bus.commit_data  = cdata;
        bus.flush        = fl;
        bus.rs1          = s1;
        bus.rs2          = s2;
        e = '{name: name, cyc: cyc_cnt, b1: b1, t1: t1, v1: v1,
              b2: b2, t2: t2, v2: v2, cnt: cnt};
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_tag = '0;
        bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0;
        bus.commit_data = '0; bus.flush = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        //    name            rdy iv ird itag  cv crd ctag cdata          fl rs1 rs2  b1 t1 v1            b2 t2 v2            cnt
        step("reset_read",    1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 5,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("issue3",        1, 1, 3, 7,    0, 0, 0, 32'h0,        0, 3,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("read3_busy",    1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 3,  0,   1, 7, 32'h0,        0, 0, 32'h0,        1);
        step("commit3",       1, 0, 0, 0,    1, 3, 7, 32'hDEADBEEF, 0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        1);
        step("read3_done",    1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 3,  3,   0, 7, 32'hDEADBEEF, 0, 7, 32'hDEADBEEF, 0);
        step("zero_reg_wr",   1, 1, 0, 5,    1, 0, 0, 32'h1234,     0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("zero_reg_rd",   1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 0,  3,   0, 0, 32'h0,        0, 7, 32'hDEADBEEF, 0);
        step("issue4_t2",     1, 1, 4, 2,    0, 0, 0, 32'h0,        0, 4,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("issue4_t9",     1, 1, 4, 9,    0, 0, 0, 32'h0,        0, 4,  0,   1, 2, 32'h0,        0, 0, 32'h0,        1);
        step("stale_commit",  1, 0, 0, 0,    1, 4, 2, 32'h11,       0, 4,  0,   1, 9, 32'h0,        0, 0, 32'h0,        1);
        step("after_stale",   1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 4,  0,   1, 9, 32'h11,       0, 0, 32'h0,        1);
        step("commit4_t9",    1, 0, 0, 0,    1, 4, 9, 32'h22,       0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        1);
        step("read4_done",    1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 4,  0,   0, 9, 32'h22,       0, 0, 32'h0,        0);
        step("issue6_t1",     1, 1, 6, 1,    0, 0, 0, 32'h0,        0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("iss_com_6",     1, 1, 6, 5,    1, 6, 1, 32'hCAFE0006, 0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        1);
        step("read6",         1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 6,  0,   1, 5, 32'hCAFE0006, 0, 0, 32'h0,        1);
        step("issue7_t2",     1, 1, 7, 2,    0, 0, 0, 32'h0,        0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        1);
        step("issue8_t4",     1, 1, 8, 4,    0, 0, 0, 32'h0,        0, 7,  0,   1, 2, 32'h0,        0, 0, 32'h0,        2);
        step("flush",         1, 1, 9, 6,    1, 8, 4, 32'h55,       1, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        3);
        step("post_flush_a",  1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 8,  9,   0, 4, 32'h55,       0, 0, 32'h0,        0);
        step("post_flush_b",  1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 6,  7,   0, 5, 32'hCAFE0006, 0, 2, 32'h0,        0);
        step("rdy_low",       0, 1, 11, 3,   1, 3, 7, 32'h99,       0, 11, 3,   0, 0, 32'h0,        0, 7, 32'hDEADBEEF, 0);
        step("rdy_held",      1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 11, 3,   0, 0, 32'h0,        0, 7, 32'hDEADBEEF, 0);
        step("issue10_t3",    1, 1, 10, 3,   0, 0, 0, 32'h0,        0, 0,  0,   0, 0, 32'h0,        0, 0, 32'h0,        0);
        step("commit10_byp",  1, 0, 0, 0,    1, 10, 3, 32'hA5,      0, 10, 10,  !BYP, 3, BYP ? 32'hA5 : 32'h0,
                                                                                  !BYP, 3, BYP ? 32'hA5 : 32'h0,    1);
        step("read10_done",   1, 0, 0, 0,    0, 0, 0, 32'h0,        0, 0,  10,  0, 0, 32'h0,        0, 3, 32'hA5,       0);

        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.commit_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
